signed_minmax_tracker: RTL
==========================

// Module: signed_minmax_tracker
// PURPOSE
//  Frame-based running signed min/max tracker; downstream consumer of comparatorSigned.
//  Accepts a stream of N-bit two's-complement samples over a valid/ready handshake.
//  Compares each sample against the stored min/max with two comparatorSigned instances.
//  Reports frame min, max and sample count, with a done pulse at end of frame.
// PARAMETERS
//  N      4  sample width, two's complement
//  FRAME  8  samples per frame, >= 1
//  CNT_W  4  counter width; 2**CNT_W > FRAME required
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      begin a frame; honoured only in IDLE
//  in_valid    in   1      sample present on in_data
//  in_data     in   N      signed sample
//  in_ready    out  1      1 only in RUN
//  min_out     out  N      smallest signed sample of current/last frame
//  max_out     out  N      largest signed sample of current/last frame
//  sample_cnt  out  CNT_W  samples accepted this frame, 0..FRAME
//  busy        out  1      1 in RUN
//  done        out  1      one-cycle pulse in DONE
//  min_idx     out  CNT_W  index of min sample (MINMAX_INDEX_EN only)
//  max_idx     out  CNT_W  index of max sample (MINMAX_INDEX_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async, any state): state=IDLE; min_out, max_out, sample_cnt,
//    busy, done, in_ready all 0; first flag cleared. Takes effect immediately, mid-frame included.
//  - FSM: IDLE -start-> RUN; RUN -accept with sample_cnt==FRAME-1-> DONE; DONE -> IDLE (unconditional).
//  - IDLE: in_ready=0, busy=0. On start: sample_cnt<=0, first<=1. min/max hold old values.
//  - RUN: in_ready=1, busy=1. Accept = in_valid & in_ready. in_valid low: nothing changes.
//  - First accepted sample: min_out<=max_out<=in_data.
//  - Later samples: comparatorSigned(x=in_data, y=min_out).lt -> min_out<=in_data;
//    comparatorSigned(x=in_data, y=max_out).gt -> max_out<=in_data. Ties (eq) never update.
//  - A single sample may update both min and max only when it is the first sample.
//  - sample_cnt increments by 1 per accept. Registered outputs; latency 1 cycle after accept edge.
//  - DONE: lasts exactly 1 cycle. done=1, in_ready=0, busy=0. Final min/max/sample_cnt=FRAME valid here.
//  - After DONE, outputs hold until the first sample of the next frame.
//  - start while in RUN or DONE: ignored. in_valid while not in RUN: not consumed.
//  - Signed range for N=4: 1000 (-8) .. 0111 (+7). No saturation or extension needed.
//  - FRAME=1: first accept goes straight to DONE.
// CONFIGURATION
//  - MINMAX_INDEX_EN defined: min_idx/max_idx ports exist.
//    Each loads the current sample_cnt value (0-based index) whenever its min/max register loads.
//    Both are 0 after reset and after the first sample.
//  - MINMAX_INDEX_EN undefined: min_idx/max_idx ports and their registers are absent.
//    All other behaviour is identical.
// TESTING
//  1. Hold rst_n=0 -> min_out=max_out=0, sample_cnt=0, in_ready=busy=done=0. Release -> stays IDLE.
//  2. start, then 8 consecutive samples 0001,1111,0111,1000,0000,0010,1010,0011 ->
//     DONE cycle shows min_out=1000, max_out=0111, sample_cnt=8, done high exactly 1 cycle.
//  3. Frame of eight 1010 samples -> min_out=max_out=1010.
//     With MINMAX_INDEX_EN: min_idx=max_idx=0 (ties never update).
//  4. in_valid=1 while IDLE -> no accept. start pulsed mid-RUN -> ignored.
//     in_valid gaps inside the frame -> count advances only on accepts; done after the 8th accept.
//  5. Reset asserted after 3 accepts -> all outputs 0 asynchronously.
//     Then start plus 8 samples -> correct fresh result.
//  6. MINMAX_INDEX_EN with stimulus of test 2 -> min_idx=3, max_idx=2.

Source files
------------

// File: rtl/signed_minmax_tracker_if.sv
// Sample-stream and result bundle for signed_minmax_tracker.
// The min_idx/max_idx result signals exist only when MINMAX_INDEX_EN is defined.
interface signed_minmax_tracker_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4
);

  logic             start;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_ready;
  logic [N-1:0]     min_out;
  logic [N-1:0]     max_out;
  logic [CNT_W-1:0] sample_cnt;
  logic             busy;
  logic             done;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] min_idx;
  logic [CNT_W-1:0] max_idx;
`endif

  // Tracker side: consumes samples, drives results.
  modport slave (
`ifdef MINMAX_INDEX_EN
    output min_idx, max_idx,
`endif
    input  start, in_valid, in_data,
    output in_ready, min_out, max_out, sample_cnt, busy, done
  );

  // Producer side: drives samples, observes results.
  modport master (
`ifdef MINMAX_INDEX_EN
    input  min_idx, max_idx,
`endif
    output start, in_valid, in_data,
    input  in_ready, min_out, max_out, sample_cnt, busy, done
  );

endinterface

// File: rtl/signed_minmax_tracker.sv
// Frame-based running signed min/max tracker.
// Accepts FRAME two's-complement samples per frame over valid/ready and reports the frame
// minimum, maximum and sample count, pulsing done for one cycle at end of frame.
// Optional feature: define MINMAX_INDEX_EN to add min_idx/max_idx (0-based sample index of the
// current min/max).
module signed_minmax_tracker #(
  parameter int unsigned N     = 4,
  parameter int unsigned FRAME = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  signed_minmax_tracker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     min_q, min_d;
  logic [N-1:0]     max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
`endif

  logic accept;
  logic in_lt_min;
  logic in_gt_max;

  assign accept = bus.in_valid & ready_q;

  // Two signed comparators (comparatorSigned x=in_data, y=stored value); ties give neither.
  always_comb begin
    in_lt_min = $signed(bus.in_data) < $signed(min_q);
    in_gt_max = $signed(bus.in_data) > $signed(max_q);
  end

  // Next-state and registered-output computation for the frame FSM.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef MINMAX_INDEX_EN
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
`endif

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        // Results of the previous frame stay visible until the next first sample.
        if (bus.start) begin
          state_d = StRun;
          cnt_d   = '0;
          first_d = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (first_q) begin
            first_d   = 1'b0;
            min_d     = bus.in_data;
            max_d     = bus.in_data;
`ifdef MINMAX_INDEX_EN
            min_idx_d = cnt_q;
            max_idx_d = cnt_q;
`endif
          end else if (in_lt_min) begin
            min_d     = bus.in_data;
`ifdef MINMAX_INDEX_EN
            min_idx_d = cnt_q;
`endif
          end else if (in_gt_max) begin
            max_d     = bus.in_data;
`ifdef MINMAX_INDEX_EN
            max_idx_d = cnt_q;
`endif
          end

          if (cnt_q == LastIdx) begin
            state_d = StDone;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MINMAX_INDEX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MINMAX_INDEX_EN
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
`endif
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.min_out    = min_q;
  assign bus.max_out    = max_q;
  assign bus.sample_cnt = cnt_q;
`ifdef MINMAX_INDEX_EN
  assign bus.min_idx    = min_idx_q;
  assign bus.max_idx    = max_idx_q;
`endif

endmodule
